// File: rtl/me_pkg.sv
// me_pkg: shared defaults, state encoding and motion-vector type for the motion estimator
package me_pkg;
  localparam int SAD_W_DEF    = 8;
  localparam int SEARCH_P_DEF = 8;
  localparam int MV_W_DEF     = 5;
  localparam int NUM_CAND     = (2 * SEARCH_P_DEF) * (2 * SEARCH_P_DEF);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  typedef logic signed [MV_W_DEF-1:0] mv_t;
endpackage

// File: rtl/mv_scan_counter.sv
// mv_scan_counter: raster x/y displacement counter over -SEARCH_P..SEARCH_P-1
//   clock/reset: clock, async active-high reset; clr: restart at (-P,-P); adv: step one candidate
//   x/y: current signed displacement; last: current candidate is the final one in the window
module mv_scan_counter
  import me_pkg::*;
#(
  parameter int SEARCH_P = SEARCH_P_DEF,
  parameter int MV_W     = MV_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   adv,
  output logic signed [MV_W-1:0] x,
  output logic signed [MV_W-1:0] y,
  output logic                   last
);
  localparam logic signed [MV_W-1:0] LO = MV_W'(-SEARCH_P);
  localparam logic signed [MV_W-1:0] HI = MV_W'(SEARCH_P - 1);
  logic signed [MV_W-1:0] r_x, r_y;
  logic w_x_end;
  always_comb begin
    w_x_end = r_x == HI;
    last    = w_x_end && r_y == HI;
    x       = r_x;
    y       = r_y;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_x <= LO;
      r_y <= LO;
    end else if (clr) begin
      r_x <= LO;
      r_y <= LO;
    end else if (adv) begin
      r_x <= w_x_end ? LO : r_x + MV_W'(1);
      if (w_x_end) r_y <= last ? LO : r_y + MV_W'(1);
    end
endmodule

// File: rtl/sad_min_selector.sv
// sad_min_selector: tracks the minimum SAD over a raster search window and reports its motion vector
//   start: begin/restart a window; sad_valid/sad_in: one candidate SAD per accepted cycle
//   best_sad/best_mv_x/best_mv_y: running minimum and its displacement; busy: scanning; done: one-cycle completion pulse
module sad_min_selector
  import me_pkg::*;
#(
  parameter int SAD_W    = SAD_W_DEF,
  parameter int SEARCH_P = SEARCH_P_DEF,
  parameter int MV_W     = MV_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   sad_valid,
  input  logic [SAD_W-1:0]       sad_in,
  output logic [SAD_W-1:0]       best_sad,
  output logic signed [MV_W-1:0] best_mv_x,
  output logic signed [MV_W-1:0] best_mv_y,
  output logic                   busy,
  output logic                   done
);
  state_e                 r_state;
  logic [SAD_W-1:0]       r_best_sad;
  logic signed [MV_W-1:0] r_mv_x, r_mv_y;
  logic                   r_busy, r_done, r_first;
  logic signed [MV_W-1:0] w_x, w_y;
  logic                   w_last, w_adv;
  // start always wins: a sample coinciding with start is discarded
  always_comb w_adv = r_state == SCAN && sad_valid && !start;
  mv_scan_counter #(.SEARCH_P(SEARCH_P), .MV_W(MV_W)) u_cnt (
    .clock(clock),
    .reset(reset),
    .clr  (start),
    .adv  (w_adv),
    .x    (w_x),
    .y    (w_y),
    .last (w_last)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_state    <= IDLE;
      r_best_sad <= '1;
      r_mv_x     <= '0;
      r_mv_y     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_first    <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_state    <= SCAN;
        r_best_sad <= '1;
        r_first    <= 1'b1;
        r_busy     <= 1'b1;
      end else begin
        case (r_state)
          SCAN: if (sad_valid) begin
            // first candidate is taken unconditionally; ties keep the earlier one
            if (r_first || sad_in < r_best_sad) begin
              r_best_sad <= sad_in;
              r_mv_x     <= w_x;
              r_mv_y     <= w_y;
              r_first    <= 1'b0;
            end
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  always_comb begin
    best_sad  = r_best_sad;
    best_mv_x = r_mv_x;
    best_mv_y = r_mv_y;
    busy      = r_busy;
    done      = r_done;
  end
endmodule

// File: doc/sad_min_selector.md
Name: sad_min_selector

Overview:
- Downstream stage of the processing element in the full-search block-matching motion estimator.
- Accepts one finished SAD (the PE accumulate value) per candidate displacement, in raster order across the search window.
- Tracks the minimum SAD and converts the winning candidate index into a signed motion vector (mv_x, mv_y).
- Issues a one-cycle done pulse when the window is exhausted.

Parameters:
SAD_W, 8, width of the SAD input and best_sad output; matches the PE accumulate width
SEARCH_P, 8, search range per axis is -SEARCH_P..SEARCH_P-1, giving (2*SEARCH_P)^2 candidates
MV_W, 5, signed motion-vector component width; must hold -SEARCH_P..SEARCH_P-1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begins a new search window and aborts any search in progress
sad_valid  in  1  sad_in holds a finished candidate SAD this cycle
sad_in  in  SAD_W  candidate SAD from the PE accumulate output
best_sad  out  SAD_W  minimum SAD found so far, registered
best_mv_x  out  MV_W  signed x displacement of best_sad, registered
best_mv_y  out  MV_W  signed y displacement of best_sad, registered
busy  out  1  high while in SCAN
done  out  1  one-cycle pulse; the search is complete and the best_* outputs are final

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-scan):
  - state=IDLE; best_sad=all ones; best_mv_x=0; best_mv_y=0; busy=0; done=0.
  - Internal x=-SEARCH_P, y=-SEARCH_P; first flag set.
- States are IDLE, SCAN, DONE.
- IDLE:
  - sad_valid is ignored.
  - start -> SCAN. On that edge: best_sad=all ones, x=y=-SEARCH_P, first flag set. busy=1 from the next cycle.
- SCAN, on each accepted sample (sad_valid=1):
  - Update when the first flag is set or sad_in < best_sad (strict less-than). Update loads best_sad=sad_in, best_mv_x=x, best_mv_y=y, then clears the first flag.
  - Ties keep the earlier candidate.
  - The first candidate is always taken, even when sad_in is all ones.
  - best_* reflect a sample one cycle after it is accepted.
- Raster advance per accepted sample:
  - x increments.
  - If x==SEARCH_P-1: x wraps to -SEARCH_P and y increments.
  - The sample at x==SEARCH_P-1 and y==SEARCH_P-1 is the last one: go to DONE.
- Gaps are allowed: sad_valid may deassert for any number of cycles; nothing advances during a gap.
- start in SCAN (including with sad_valid in the same cycle): the sample is discarded and the window restarts exactly as from IDLE.
- DONE:
  - done=1 for exactly one cycle, the cycle after the last sample is accepted; busy=0 in that cycle.
  - Unconditional transition to IDLE. sad_valid is ignored.
  - start arriving in DONE is honoured as an IDLE start: the next state is SCAN with registers cleared.
- best_* hold their value after DONE until the next start or reset.
- Width and sign rules:
  - x and y are MV_W-bit two's-complement.
  - The comparison is unsigned on SAD_W bits. There is no saturation, because sad_in is already bounded by the PE.
- Latency: done follows the final sad_valid by 1 cycle. Total search cycles = candidates + gap cycles + 1.

Decomposition:
- Shared package me_pkg holds:
  - SAD_W and SEARCH_P defaults.
  - NUM_CAND = (2*SEARCH_P)^2.
  - The state enum {IDLE, SCAN, DONE}.
  - A signed motion-vector type of MV_W bits.
- One sub-module, mv_scan_counter: a raster x/y counter with clear, advance enable and a last-candidate flag. It is reused by the upstream address generator.
- Compare/update logic and the FSM stay in sad_min_selector.

Test Plan:
The bench uses SEARCH_P=2: 16 candidates, range -2..1, raster index i maps to x=-2+i%4, y=-2+i/4.
1. Reset with no start -> best_sad=8'hFF, best_mv_x=0, best_mv_y=0, busy=0, done=0. sad_valid pulses in IDLE change nothing.
2. start, then 16 back-to-back samples, all 50 except index 6 = 3 -> best_sad=3, mv=(0,-1). done is high exactly one cycle after the 16th sample; busy is low in that cycle.
3. Samples with index 2 = 0 and index 9 = 0, others 20 -> best_sad=0, mv=(0,-2): the tie keeps the earlier candidate.
4. All 16 samples = 8'hFF -> best_sad=8'hFF, mv=(-2,-2): the first candidate is taken unconditionally.
5. Same data as scenario 2 with sad_valid on alternate cycles -> identical result; done one cycle after the 16th valid.
6. Abort and reset mid-scan:
   - start again after 7 samples, then 16 samples with index 15 = 1 -> result (1, 1, 1). The pre-abort data has no effect.
   - Separately, reset after 5 samples -> outputs return to reset values asynchronously, before the next clock edge.
